// File: rtl/mavg_pkg.sv
// Shared helpers and types for the multichannel moving average block.
package mavg_pkg;

    localparam int DEF_CHANNELS         = 2;
    localparam int DEF_IN_BITS          = 16;
    localparam int DEF_MAX_LOG2_SAMPLES = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int sum_bits(input int in_bits, input int max_log2);
        return in_bits + max_log2;
    endfunction

    // Widens the low `bits` bits of value to 64 bits, replicating bit bits-1.
    function automatic logic signed [63:0] sign_extend(input logic [63:0] value, input int bits);
        logic [63:0] mask;
        mask = ~64'd0 << bits;
        return $signed(value[bits-1] ? (value | mask) : (value & ~mask));
    endfunction

    localparam int DEF_SUM_BITS = sum_bits(DEF_IN_BITS, DEF_MAX_LOG2_SAMPLES);

    typedef logic signed [DEF_SUM_BITS-1:0] sum_vec_t [DEF_CHANNELS];

endpackage

// File: rtl/multichannel_moving_average_if.sv
// Sample/result bus of the moving average block; master drives samples, slave returns results.
interface multichannel_moving_average_if
    import mavg_pkg::*;
#(
    parameter int CHANNELS         = DEF_CHANNELS,
    parameter int IN_BITS          = DEF_IN_BITS,
    parameter int MAX_LOG2_SAMPLES = DEF_MAX_LOG2_SAMPLES
);
    localparam int SUM_BITS = sum_bits(IN_BITS, MAX_LOG2_SAMPLES);
    localparam int WIN_BITS = clog2(MAX_LOG2_SAMPLES + 1);

    logic                         in_valid;
    logic [CHANNELS*IN_BITS-1:0]  in_data;
    logic [WIN_BITS-1:0]          log2_win;
    logic                         flush_i;
    logic                         out_valid;
    logic [CHANNELS*SUM_BITS-1:0] sum_out;
    logic [CHANNELS*IN_BITS-1:0]  avg_out;
    logic                         primed;

    modport master (
        output in_valid, in_data, log2_win, flush_i,
        input  out_valid, sum_out, avg_out, primed
    );

    modport slave (
        input  in_valid, in_data, log2_win, flush_i,
        output out_valid, sum_out, avg_out, primed
    );

endinterface

// File: rtl/mavg_sample_ram.sv
// Simple dual-port sample history RAM: read-first, one-cycle registered read, contents not reset.
module mavg_sample_ram #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_data
);

    logic [WIDTH-1:0] r_mem [1 << ADDR_BITS];
    logic [WIDTH-1:0] r_rd_data;

    // Both ports act on the same edge, so a colliding read sees the word being replaced.
    always_ff @(posedge clk) begin
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/multichannel_moving_average.sv
// Boxcar averager over a power-of-two window for CHANNELS signed streams, history kept in a circular RAM.
// Build option MAVG_ROUND_EN: round-half-up with positive saturation on avg_out (sum_out unaffected).
module multichannel_moving_average
    import mavg_pkg::*;
#(
    parameter int CHANNELS         = DEF_CHANNELS,
    parameter int IN_BITS          = DEF_IN_BITS,
    parameter int MAX_LOG2_SAMPLES = DEF_MAX_LOG2_SAMPLES
) (
    input logic                          clk,
    input logic                          rst_n,
    multichannel_moving_average_if.slave s_bus
);

    localparam int SUM_BITS = sum_bits(IN_BITS, MAX_LOG2_SAMPLES);
    localparam int WIN_BITS = clog2(MAX_LOG2_SAMPLES + 1);
    localparam int AW       = MAX_LOG2_SAMPLES;
    localparam int DW       = CHANNELS * IN_BITS;

    logic [WIN_BITS-1:0]          w_win_clamp;
    logic [WIN_BITS-1:0]          r_win_q;
    logic [AW:0]                  w_n;
    logic [AW-1:0]                r_wr_ptr;
    logic [AW-1:0]                w_rd_addr;
    logic [DW-1:0]                w_rd_data;
    logic                         w_flush;
    logic                         w_accept;
    logic                         w_last;
    logic                         r_s1_valid;
    logic [AW:0]                  r_fill;
    logic                         r_primed;
    logic                         r_out_valid;
    logic [CHANNELS*SUM_BITS-1:0] r_sum_out;
    logic [DW-1:0]                r_avg_out;
    logic [CHANNELS*SUM_BITS-1:0] w_sum_flat;
    logic [DW-1:0]                w_avg;

    logic signed [SUM_BITS-1:0] w_in_ext    [CHANNELS];
    logic signed [SUM_BITS-1:0] r_s1_sample [CHANNELS];
    logic signed [SUM_BITS-1:0] r_sum       [CHANNELS];
    logic signed [SUM_BITS-1:0] w_sum_next  [CHANNELS];

    assign w_win_clamp = (s_bus.log2_win > WIN_BITS'(MAX_LOG2_SAMPLES)) ?
                         WIN_BITS'(MAX_LOG2_SAMPLES) : s_bus.log2_win;

    // A window change restarts averaging exactly like an explicit flush.
    assign w_flush   = s_bus.flush_i | (w_win_clamp != r_win_q);
    assign w_accept  = s_bus.in_valid & ~w_flush;
    assign w_n       = (AW+1)'(1) << r_win_q;
    assign w_rd_addr = r_wr_ptr - w_n[AW-1:0];
    assign w_last    = (r_fill == (w_n - (AW+1)'(1)));

    mavg_sample_ram #(
        .WIDTH     (DW),
        .ADDR_BITS (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_bus.in_data),
        .i_rd_en   (w_accept),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [SUM_BITS-1:0] w_old_ext;

        assign w_in_ext[c] = SUM_BITS'(sign_extend(64'(s_bus.in_data[c*IN_BITS +: IN_BITS]), IN_BITS));
        assign w_old_ext   = SUM_BITS'(sign_extend(64'(w_rd_data[c*IN_BITS +: IN_BITS]), IN_BITS));
        assign w_sum_next[c] = r_sum[c] + r_s1_sample[c] - (r_primed ? w_old_ext : '0);
        assign w_sum_flat[c*SUM_BITS +: SUM_BITS] = w_sum_next[c];

`ifdef MAVG_ROUND_EN
        localparam logic signed [SUM_BITS:0] AVG_MAX =
            {{(SUM_BITS-IN_BITS+2){1'b0}}, {(IN_BITS-1){1'b1}}};
        logic signed [SUM_BITS:0] w_round_add;
        logic signed [SUM_BITS:0] w_rounded;
        logic signed [SUM_BITS:0] w_shifted;

        assign w_round_add = (r_win_q == '0) ? '0 : ((SUM_BITS+1)'(1) << (r_win_q - WIN_BITS'(1)));
        assign w_rounded   = {w_sum_next[c][SUM_BITS-1], w_sum_next[c]} + w_round_add;
        assign w_shifted   = w_rounded >>> r_win_q;
        assign w_avg[c*IN_BITS +: IN_BITS] = (w_shifted > AVG_MAX) ?
                                             AVG_MAX[IN_BITS-1:0] : w_shifted[IN_BITS-1:0];
`else
        assign w_avg[c*IN_BITS +: IN_BITS] = IN_BITS'(w_sum_next[c] >>> r_win_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_q     <= w_win_clamp;
            r_wr_ptr    <= '0;
            r_s1_valid  <= 1'b0;
            r_fill      <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum_out   <= '0;
            r_avg_out   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_sum[c]       <= '0;
                r_s1_sample[c] <= '0;
            end
        end else begin
            r_win_q     <= w_win_clamp;
            r_s1_valid  <= w_accept;
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                for (int c = 0; c < CHANNELS; c++) r_s1_sample[c] <= w_in_ext[c];
            end
            if (w_flush) begin
                r_fill   <= '0;
                r_primed <= 1'b0;
                for (int c = 0; c < CHANNELS; c++) r_sum[c] <= '0;
            end else if (r_s1_valid) begin
                for (int c = 0; c < CHANNELS; c++) r_sum[c] <= w_sum_next[c];
                if (!r_primed) r_fill <= r_fill + (AW+1)'(1);
                if (w_last) r_primed <= 1'b1;
                // The Nth sample itself already produces a result.
                if (r_primed || w_last) begin
                    r_out_valid <= 1'b1;
                    r_sum_out   <= w_sum_flat;
                    r_avg_out   <= w_avg;
                end
            end
        end
    end

    assign s_bus.out_valid = r_out_valid;
    assign s_bus.sum_out   = r_sum_out;
    assign s_bus.avg_out   = r_avg_out;
    assign s_bus.primed    = r_primed;

endmodule

// File: tb/tb_multichannel_moving_average.sv
// Directed bench for multichannel_moving_average; expected values are hand-computed per step.
module tb_multichannel_moving_average;
    import mavg_pkg::*;

    localparam int CH  = DEF_CHANNELS;
    localparam int IB  = DEF_IN_BITS;
    localparam int ML  = DEF_MAX_LOG2_SAMPLES;
    localparam int SB  = DEF_SUM_BITS;
`ifdef MAVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multichannel_moving_average_if #(.CHANNELS(CH), .IN_BITS(IB), .MAX_LOG2_SAMPLES(ML)) bus ();

    multichannel_moving_average #(.CHANNELS(CH), .IN_BITS(IB), .MAX_LOG2_SAMPLES(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [IB-1:0] d0, input logic signed [IB-1:0] d1);
        bus.in_valid = 1'b1;
        bus.in_data  = {d1, d0};
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] sum_ch(input int c);
        logic signed [SB-1:0] v;
        v = bus.sum_out[c*SB +: SB];
        return v;
    endfunction

    function automatic logic signed [63:0] avg_ch(input int c);
        logic signed [IB-1:0] v;
        v = bus.avg_out[c*IB +: IB];
        return v;
    endfunction

    task automatic check_ov(input string tag, input logic exp);
        check({tag, "_ov"}, bus.out_valid, exp);
    endtask

    task automatic check_out(input string tag, input longint s0, input longint a0,
                             input longint s1, input longint a1);
        sum_vec_t es;
        longint   ea [CH];
        es[0] = SB'(s0);
        es[1] = SB'(s1);
        ea[0] = a0;
        ea[1] = a1;
        check_ov(tag, 1'b1);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s_sum%0d", tag, c), sum_ch(c), es[c]);
            check($sformatf("%s_avg%0d", tag, c), avg_ch(c), ea[c]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.log2_win = 4'd2;
        bus.flush_i  = 1'b0;
        repeat (3) step();
        check("rst_ov", bus.out_valid, 0);
        check("rst_sum", bus.sum_out, 0);
        check("rst_avg", bus.avg_out, 0);
        check("rst_primed", bus.primed, 0);
        rst_n = 1'b1;

        // N=4: ch0 ramp, ch1 negative ramp to exercise floor on negatives
        send(4, -1);
        send(8, -2);   check_ov("n4_s1", 1'b0);
        send(12, -3);  check_ov("n4_s2", 1'b0);
        send(16, -4);  check_ov("n4_s3", 1'b0);
        check("n4_unprimed", bus.primed, 0);
        send(20, -5);  check_out("n4_first", 40, 10, -10, RND ? -2 : -3);
        check("n4_primed", bus.primed, 1);
        idle();        check_out("n4_second", 56, 14, -14, RND ? -3 : -4);
        idle();        check_ov("n4_gap", 1'b0);
        check("n4_hold", sum_ch(0), 56);

        // N=256 via a clamped out-of-range select; pointer wrap and read/write collision
        bus.log2_win = 4'd12;
        idle();
        for (int i = 1; i <= 300; i++) begin
            send(-3, -3);
            check_ov($sformatf("n256_%0d", i), i >= 257);
            check($sformatf("n256_primed_%0d", i), bus.primed, i >= 257);
            if (i >= 257) check_out($sformatf("n256_val_%0d", i), -768, -3, -768, -3);
        end
        idle();        check_out("n256_last", -768, -3, -768, -3);

        // flush with N=2
        bus.log2_win = 4'd1;
        idle();
        send(10, 0);
        send(20, 0);   check_ov("fl_pre", 1'b0);
        send(30, 0);   check_out("fl_primed", 30, 15, 0, 0);
        bus.flush_i = 1'b1;
        send(40, 0);
        bus.flush_i = 1'b0;
        check_ov("fl_kill", 1'b0);
        check("fl_primed_low", bus.primed, 0);
        check("fl_hold", sum_ch(0), 30);
        send(5, 0);    check_ov("fl_re1", 1'b0);
        send(7, 0);    check_ov("fl_re2", 1'b0);
        idle();        check_out("fl_new", 12, 6, 0, 0);

        // window 3 -> 1 mid-stream acts as a flush
        bus.log2_win = 4'd3;
        idle();
        for (int i = 1; i <= 8; i++) begin
            send(100, -100);
            check_ov($sformatf("w8_%0d", i), 1'b0);
        end
        send(100, -100); check_out("w8_full", 800, 100, -800, -100);
        bus.log2_win = 4'd1;
        send(999, 999);  check_ov("wc_kill", 1'b0);
        check("wc_primed_low", bus.primed, 0);
        send(1, -1);     check_ov("wc_re1", 1'b0);
        send(3, -3);     check_ov("wc_re2", 1'b0);
        idle();          check_out("wc_new", 4, 2, -4, -2);

        // rounding and full-scale with N=2
        bus.flush_i = 1'b1;
        idle();
        bus.flush_i = 1'b0;
        send(1, -32768);
        send(2, -32768);
        idle();          check_out("rnd_half", 3, RND ? 2 : 1, -65536, -32768);
        send(32767, -32768);
        send(32767, -32768);
        idle();          check_out("full_scale", 65534, 32767, -65536, -32768);

        // reset during continuous input
        send(9, 9);
        send(9, 9);
        send(9, 9);
        rst_n = 1'b0;
        send(9, 9);
        check("rs_ov", bus.out_valid, 0);
        check("rs_sum", bus.sum_out, 0);
        check("rs_avg", bus.avg_out, 0);
        check("rs_primed", bus.primed, 0);
        rst_n = 1'b1;
        send(9, 9);      check_ov("rs_re1", 1'b0);
        send(9, 9);      check_ov("rs_re2", 1'b0);
        idle();          check_out("rs_new", 18, 9, 18, 9);

        // N=1: output follows input from the first sample
        bus.log2_win = 4'd0;
        idle();
        send(7, -7);     check_ov("n1_empty", 1'b0);
        send(-20, 5);    check_out("n1_a", 7, 7, -7, -7);
        idle();          check_out("n1_b", -20, -20, 5, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
